// File: rtl/comp_pkg.sv
// Shared state encodings and index-width helper for the iterative comparator.
package comp_pkg;

    // Controller states, 2-bit encoded
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2, used to size the chunk index counter
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/comp_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice (gt/eq convention).
module comp_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             gt,
    output logic             eq
);

    assign gt = (a > b);
    assign eq = (a == b);

endmodule

// File: rtl/comp_iter.sv
// Multi-cycle magnitude comparator: walks the operands CHUNK bits per cycle,
// MSB chunk first, and stops on the first chunk that differs.
module comp_iter
    import comp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int NCHUNK = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
    localparam int IDXW   = (clog2(NCHUNK) < 1) ? 1 : clog2(NCHUNK);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    // Reject parameter sets that do not split the operands into whole chunks
    generate
        if (CHUNK < 1) begin : g_chunk_too_small
            $error("comp_iter: CHUNK must be at least 1");
        end else if ((WIDTH % CHUNK) != 0) begin : g_width_not_multiple
            $error("comp_iter: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    state_t            state_reg, state_next;
    logic [IDXW-1:0]   idx_reg,   idx_next;
    logic [WIDTH-1:0]  a_reg,     a_next;
    logic [WIDTH-1:0]  b_reg,     b_next;
    logic              eq_reg,    eq_next;
    logic              gt_reg,    gt_next;
    logic              lt_reg,    lt_next;

    logic [WIDTH-1:0]  sign_mask;
    logic [CHUNK-1:0]  a_chunks [NCHUNK];
    logic [CHUNK-1:0]  b_chunks [NCHUNK];
    logic [CHUNK-1:0]  chunk_a;
    logic [CHUNK-1:0]  chunk_b;
    logic              chunk_gt;
    logic              chunk_eq;

    // Flipping the sign bit maps two's-complement order onto unsigned order,
    // so a signed compare becomes an unsigned one that only touches chunk 0
    always_comb begin
        sign_mask            = '0;
        sign_mask[WIDTH-1]   = is_signed;
    end

    // Slice the latched operands into chunks, index 0 being the MSB chunk
    generate
        for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_slice
            assign a_chunks[gi] = a_reg[WIDTH-1-gi*CHUNK -: CHUNK];
            assign b_chunks[gi] = b_reg[WIDTH-1-gi*CHUNK -: CHUNK];
        end
    endgenerate

    assign chunk_a = a_chunks[idx_reg];
    assign chunk_b = b_chunks[idx_reg];

    comp_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a  (chunk_a),
        .b  (chunk_b),
        .gt (chunk_gt),
        .eq (chunk_eq)
    );

    // State, index, operand and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            eq_reg    <= 1'b0;
            gt_reg    <= 1'b0;
            lt_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            eq_reg    <= eq_next;
            gt_reg    <= gt_next;
            lt_reg    <= lt_next;
        end
    end

    // Next-state logic: accept, walk chunks with early exit, hold result until taken
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        eq_next    = eq_reg;
        gt_next    = gt_reg;
        lt_next    = lt_reg;

        case (state_reg)
            IDLE: begin
                if (start_valid) begin
                    state_next = RUN;
                    idx_next   = '0;
                    a_next     = a ^ sign_mask;
                    b_next     = b ^ sign_mask;
                end
            end
            RUN: begin
                if (!chunk_eq) begin
                    state_next = DONE;
                    eq_next    = 1'b0;
                    gt_next    = chunk_gt;
                    lt_next    = !chunk_gt;
                end else if (idx_reg == LAST_IDX) begin
                    state_next = DONE;
                    eq_next    = 1'b1;
                    gt_next    = 1'b0;
                    lt_next    = 1'b0;
                end else begin
                    idx_next   = idx_reg + IDXW'(1);
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_next = IDLE;
                    eq_next    = 1'b0;
                    gt_next    = 1'b0;
                    lt_next    = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign start_ready = (state_reg == IDLE);
    assign res_valid   = (state_reg == DONE);
    assign eq          = eq_reg;
    assign gt          = gt_reg;
    assign lt          = lt_reg;

endmodule

// File: tb/tb_comp_iter.sv
// Directed and randomised checks of the iterative comparator.
module tb_comp_iter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_valid;
    logic        res_ready;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        start_ready;
    logic        res_valid;
    logic        eq;
    logic        gt;
    logic        lt;

    // Wide instances (index 0: WIDTH=64 CHUNK=16, index 1: WIDTH=64 CHUNK=1)
    logic [63:0] wa;
    logic [63:0] wb;
    logic        ws;
    logic [1:0]  w_sv;
    logic [1:0]  w_rr;
    logic [1:0]  w_sr;
    logic [1:0]  w_rv;
    logic [1:0]  w_eq;
    logic [1:0]  w_gt;
    logic [1:0]  w_lt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    comp_iter #(.WIDTH(32), .CHUNK(8)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .is_signed   (is_signed),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .eq          (eq),
        .gt          (gt),
        .lt          (lt)
    );

    comp_iter #(.WIDTH(64), .CHUNK(16)) u_w16 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (w_sv[0]),
        .start_ready (w_sr[0]),
        .a           (wa),
        .b           (wb),
        .is_signed   (ws),
        .res_valid   (w_rv[0]),
        .res_ready   (w_rr[0]),
        .eq          (w_eq[0]),
        .gt          (w_gt[0]),
        .lt          (w_lt[0])
    );

    comp_iter #(.WIDTH(64), .CHUNK(1)) u_w1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (w_sv[1]),
        .start_ready (w_sr[1]),
        .a           (wa),
        .b           (wb),
        .is_signed   (ws),
        .res_valid   (w_rv[1]),
        .res_ready   (w_rr[1]),
        .eq          (w_eq[1]),
        .gt          (w_gt[1]),
        .lt          (w_lt[1])
    );

    function automatic logic [2:0] model32(input logic [31:0] x, input logic [31:0] y, input logic s);
        if (s) return {x == y, $signed(x) > $signed(y), $signed(x) < $signed(y)};
        return {x == y, x > y, x < y};
    endfunction

    function automatic logic [2:0] model64(input logic [63:0] x, input logic [63:0] y, input logic s);
        if (s) return {x == y, $signed(x) > $signed(y), $signed(x) < $signed(y)};
        return {x == y, x > y, x < y};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE; lat = edges after the accept edge until res_valid
    task automatic run_req(input logic [31:0] ra, input logic [31:0] rb, input logic rs,
                           output int lat, output logic [2:0] res);
        a           = ra;
        b           = rb;
        is_signed   = rs;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        lat = 0;
        while (!res_valid && lat < 200) begin
            tick();
            lat++;
        end
        if (!res_valid) lat = -1;
        res = {eq, gt, lt};
        $display("txn a=%h b=%h signed=%0b eq/gt/lt=%b latency=%0d", ra, rb, rs, res, lat);
    endtask

    task automatic release_res();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (start_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_start_ready: got %b expected 1", start_ready);
        end
        checks++;
        if (res_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_res_valid: got %b expected 0", res_valid);
        end
        checks++;
        if ({eq, gt, lt} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags: got eq/gt/lt=%b expected 000", {eq, gt, lt});
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({start_ready, res_valid} !== 2'b10) begin
            failures++;
            $display("FAIL reset_idle_after_release: got ready/valid=%b expected 10", {start_ready, res_valid});
        end
    endtask

    task automatic test_equal();
        int lat;
        logic [2:0] res;
        run_req(32'hDEADBEEF, 32'hDEADBEEF, 1'b0, lat, res);
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL equal_latency: got %0d expected 4", lat);
        end
        checks++;
        if (res !== 3'b100) begin
            failures++;
            $display("FAIL equal_result: got eq/gt/lt=%b expected 100", res);
        end
        checks++;
        if (start_ready !== 1'b0) begin
            failures++;
            $display("FAIL equal_ready_in_done: got %b expected 0", start_ready);
        end
        release_res();
        checks++;
        if ({start_ready, res_valid, eq, gt, lt} !== 5'b10000) begin
            failures++;
            $display("FAIL equal_after_handshake: got ready/valid/eq/gt/lt=%b expected 10000",
                     {start_ready, res_valid, eq, gt, lt});
        end
    endtask

    task automatic test_msb_chunk();
        int lat;
        logic [2:0] res;
        run_req(32'h80000000, 32'h00000001, 1'b0, lat, res);
        checks++;
        if (lat !== 1 || res !== 3'b010) begin
            failures++;
            $display("FAIL msb_unsigned: got latency=%0d eq/gt/lt=%b expected 1 010", lat, res);
        end
        release_res();
        run_req(32'h80000000, 32'h00000001, 1'b1, lat, res);
        checks++;
        if (lat !== 1 || res !== 3'b001) begin
            failures++;
            $display("FAIL msb_signed: got latency=%0d eq/gt/lt=%b expected 1 001", lat, res);
        end
        release_res();
    endtask

    task automatic test_late_chunks();
        int lat;
        logic [2:0] res;
        run_req(32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, lat, res);
        checks++;
        if (lat !== 4 || res !== 3'b010) begin
            failures++;
            $display("FAIL chunk3_signed: got latency=%0d eq/gt/lt=%b expected 4 010", lat, res);
        end
        release_res();
        run_req(32'h00001200, 32'h00003400, 1'b0, lat, res);
        checks++;
        if (lat !== 3 || res !== 3'b001) begin
            failures++;
            $display("FAIL chunk2_unsigned: got latency=%0d eq/gt/lt=%b expected 3 001", lat, res);
        end
        release_res();
        run_req(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, lat, res);
        checks++;
        if (lat !== 1 || res !== 3'b010) begin
            failures++;
            $display("FAIL max_vs_minus1_signed: got latency=%0d eq/gt/lt=%b expected 1 010", lat, res);
        end
        release_res();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [2:0] res;
        run_req(32'h80000000, 32'h00000001, 1'b0, lat, res);
        checks++;
        if (lat !== 1 || res !== 3'b010) begin
            failures++;
            $display("FAIL bp_initial: got latency=%0d eq/gt/lt=%b expected 1 010", lat, res);
        end
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                start_valid = 1'b1;
                a           = 32'h00000000;
                b           = 32'hFFFFFFFF;
                is_signed   = 1'b1;
            end
            tick();
            checks++;
            if ({res_valid, start_ready, eq, gt, lt} !== 5'b10010) begin
                failures++;
                $display("FAIL bp_hold_cycle%0d: got valid/ready/eq/gt/lt=%b expected 10010",
                         i, {res_valid, start_ready, eq, gt, lt});
            end
        end
        start_valid = 1'b0;
        release_res();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({start_ready, res_valid, eq, gt, lt} !== 5'b10000) begin
                failures++;
                $display("FAIL bp_idle_after%0d: got ready/valid/eq/gt/lt=%b expected 10000",
                         i, {start_ready, res_valid, eq, gt, lt});
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        logic [2:0] res;
        a           = 32'hDEADBEEF;
        b           = 32'hDEADBEEF;
        is_signed   = 1'b0;
        start_valid = 1'b1;
        tick();                 // accept edge k
        start_valid = 1'b0;
        tick();                 // edge k+1
        rst_n = 1'b0;
        tick();                 // edge k+2 samples reset
        checks++;
        if ({start_ready, res_valid, eq, gt, lt} !== 5'b10000) begin
            failures++;
            $display("FAIL midrun_reset_state: got ready/valid/eq/gt/lt=%b expected 10000",
                     {start_ready, res_valid, eq, gt, lt});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (res_valid !== 1'b0) begin
                failures++;
                $display("FAIL midrun_no_result%0d: got res_valid=%b expected 0", i, res_valid);
            end
        end
        run_req(32'h00001200, 32'h00003400, 1'b0, lat, res);
        checks++;
        if (lat !== 3 || res !== 3'b001) begin
            failures++;
            $display("FAIL midrun_recovery: got latency=%0d eq/gt/lt=%b expected 3 001", lat, res);
        end
        release_res();
    endtask

    task automatic test_back_to_back();
        logic [31:0] qa [3];
        logic [31:0] qb [3];
        logic        qs [3];
        logic [2:0]  exp_res;
        int          cnt;
        qa[0] = $urandom;           qb[0] = $urandom;                 qs[0] = 1'b0;
        qa[1] = $urandom;           qb[1] = qa[1] ^ 32'h00000040;     qs[1] = 1'b1;
        qa[2] = $urandom | 32'h80000000; qb[2] = $urandom & 32'h7FFFFFFF; qs[2] = 1'b1;
        a           = qa[0];
        b           = qb[0];
        is_signed   = qs[0];
        start_valid = 1'b1;
        res_ready   = 1'b1;
        tick();                 // accept of request 0
        for (int i = 0; i < 3; i++) begin
            cnt = 0;
            while (!res_valid && cnt < 200) begin
                tick();
                cnt++;
            end
            exp_res = model32(qa[i], qb[i], qs[i]);
            $display("txn a=%h b=%h signed=%0b eq/gt/lt=%b latency=%0d", qa[i], qb[i], qs[i], {eq, gt, lt}, cnt);
            checks++;
            if (res_valid !== 1'b1 || {eq, gt, lt} !== exp_res) begin
                failures++;
                $display("FAIL b2b_result%0d: got valid=%b eq/gt/lt=%b expected 1 %b",
                         i, res_valid, {eq, gt, lt}, exp_res);
            end
            tick();             // result handshake edge
            checks++;
            if ({start_ready, res_valid} !== 2'b10) begin
                failures++;
                $display("FAIL b2b_idle%0d: got ready/valid=%b expected 10", i, {start_ready, res_valid});
            end
            if (i < 2) begin
                a         = qa[i+1];
                b         = qb[i+1];
                is_signed = qs[i+1];
            end else begin
                start_valid = 1'b0;
            end
            tick();             // next accept edge
            if (i < 2) begin
                checks++;
                if (start_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_accept%0d: got start_ready=%b expected 0", i + 1, start_ready);
                end
            end
        end
        res_ready = 1'b0;
    endtask

    // Randomised pairs on one of the wide instances; nchunk is its chunk count
    task automatic test_wide(input int sel, input int nchunk, input int n);
        logic [2:0] exp_res;
        logic [2:0] got;
        int         lat;
        int         mode;
        for (int t = 0; t < n; t++) begin
            wa   = {$urandom, $urandom};
            mode = $urandom_range(0, 3);
            case (mode)
                0:       wb = {$urandom, $urandom};
                1:       wb = wa;
                2:       wb = wa ^ (64'h1 << $urandom_range(0, 63));
                default: wb = {wa[63:32], $urandom};
            endcase
            ws = 1'($urandom_range(0, 1));
            w_sv[sel] = 1'b1;
            tick();
            w_sv[sel] = 1'b0;
            lat = 0;
            while (!w_rv[sel] && lat < 200) begin
                tick();
                lat++;
            end
            got     = {w_eq[sel], w_gt[sel], w_lt[sel]};
            exp_res = model64(wa, wb, ws);
            $display("txn w%0d a=%h b=%h signed=%0b eq/gt/lt=%b latency=%0d", sel, wa, wb, ws, got, lat);
            checks++;
            if (w_rv[sel] !== 1'b1 || got !== exp_res) begin
                failures++;
                $display("FAIL wide%0d_result%0d: got valid=%b eq/gt/lt=%b expected 1 %b",
                         sel, t, w_rv[sel], got, exp_res);
            end
            if (mode == 1) begin
                checks++;
                if (lat !== nchunk) begin
                    failures++;
                    $display("FAIL wide%0d_equal_latency%0d: got %0d expected %0d", sel, t, lat, nchunk);
                end
            end
            w_rr[sel] = 1'b1;
            tick();
            w_rr[sel] = 1'b0;
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        start_valid = 1'b0;
        res_ready   = 1'b0;
        is_signed   = 1'b0;
        a           = '0;
        b           = '0;
        wa          = '0;
        wb          = '0;
        ws          = 1'b0;
        w_sv        = '0;
        w_rr        = '0;

        test_reset();
        test_equal();
        test_msb_chunk();
        test_late_chunks();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        test_wide(0, 4, 300);
        test_wide(1, 64, 150);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
